// File: rtl/fx_mul_pipe_if.sv
// Handshake and data bundle for the fx_mul_pipe fixed-point multiplier.
interface fx_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  out_tag;
    logic             ovf;

    modport master (
        output in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, ovf
    );

    modport slave (
        input  in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, ovf
    );
endinterface

// File: rtl/fx_mul_pipe.sv
// Pipelined signed fixed-point multiplier with global stall and tag sideband.
// Define FXMUL_SAT_EN to saturate the result and report clamps on ovf; otherwise the result wraps.
module fx_mul_pipe #(
    parameter int WIDTH   = 32,
    parameter int QFRAC   = 16,
    parameter int LATENCY = 2,
    parameter int ROUND   = 1,
    parameter int TAGW    = 4
) (
    input logic         clk,
    input logic         rst_n,
    fx_mul_pipe_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] RND_ADD =
        (ROUND != 0) ? ({{(PW-1){1'b0}}, 1'b1} << (QFRAC - 1)) : '0;

    logic stall;

    // Operand register; the product is formed from these so the multiplier sees registered inputs.
    logic             v0;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAGW-1:0]  tag_q;

    logic             v_q [1:LATENCY];
    logic [WIDTH-1:0] r_q [1:LATENCY];
    logic [TAGW-1:0]  t_q [1:LATENCY];

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_rnd;
    logic [WIDTH-1:0]     res_c;
    logic                 ovf_c;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        prod  = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        p_rnd = prod + RND_ADD;
    end

`ifdef FXMUL_SAT_EN
    logic signed [PW-1:0] s_w;
    logic                 o_q [1:LATENCY];

    // The value fits when every bit above the result's sign bit matches it.
    always_comb begin
        s_w   = p_rnd >>> QFRAC;
        res_c = s_w[WIDTH-1:0];
        ovf_c = 1'b0;
        if (s_w[PW-1:WIDTH-1] != '0 && s_w[PW-1:WIDTH-1] != '1) begin
            ovf_c = 1'b1;
            res_c = s_w[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= LATENCY; i++) o_q[i] <= 1'b0;
        end else if (!stall) begin
            o_q[1] <= ovf_c;
            for (int i = 2; i <= LATENCY; i++) o_q[i] <= o_q[i-1];
        end
    end

    assign bus.ovf = o_q[LATENCY];
`else
    always_comb begin
        res_c = WIDTH'(p_rnd >>> QFRAC);
        ovf_c = 1'b0;
    end

    assign bus.ovf = ovf_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            for (int i = 1; i <= LATENCY; i++) begin
                v_q[i] <= 1'b0;
                r_q[i] <= '0;
                t_q[i] <= '0;
            end
        end else if (!stall) begin
            v0     <= bus.in_valid;
            a_q    <= bus.a;
            b_q    <= bus.b;
            tag_q  <= bus.in_tag;
            v_q[1] <= v0;
            r_q[1] <= res_c;
            t_q[1] <= tag_q;
            for (int i = 2; i <= LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                r_q[i] <= r_q[i-1];
                t_q[i] <= t_q[i-1];
            end
        end
    end

    assign bus.out_valid = v_q[LATENCY];
    assign bus.result    = r_q[LATENCY];
    assign bus.out_tag   = t_q[LATENCY];

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Randomized and directed bench for fx_mul_pipe against an arithmetic reference model.
module tb_fx_mul_pipe;

    localparam int WIDTH = 32;
    localparam int QFRAC = 16;
    localparam int LAT   = 2;
    localparam int RND   = 1;
    localparam int TAGW  = 4;

`ifdef FXMUL_SAT_EN
    localparam logic [31:0] EXP_BIGPOS = 32'h7FFF_FFFF;
    localparam logic        OVF_BIGPOS = 1'b1;
    localparam logic [31:0] EXP_BIGNEG = 32'h8000_0000;
    localparam logic        OVF_BIGNEG = 1'b1;
`else
    localparam logic [31:0] EXP_BIGPOS = 32'hFFFE_0000;
    localparam logic        OVF_BIGPOS = 1'b0;
    localparam logic [31:0] EXP_BIGNEG = 32'h0000_0000;
    localparam logic        OVF_BIGNEG = 1'b0;
`endif

    typedef struct {
        logic [31:0] r;
        logic [3:0]  t;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fx_mul_pipe_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus();

    fx_mul_pipe #(
        .WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(LAT), .ROUND(RND), .TAGW(TAGW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Plain 64-bit arithmetic: full product, optional half-LSB add, floor shift, clamp or wrap.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        longint p;
        longint s;
        exp_t   e;
        p = longint'($signed(a)) * longint'($signed(b));
        if (RND != 0) p = p + (longint'(1) <<< (QFRAC - 1));
        s = p >>> QFRAC;
        e.t = t;
        e.r = 32'(s);
        e.o = 1'b0;
`ifdef FXMUL_SAT_EN
        if (s > longint'(32'h7FFF_FFFF)) begin
            e.r = 32'h7FFF_FFFF;
            e.o = 1'b1;
        end else if (s < -(longint'(1) <<< 31)) begin
            e.r = 32'h8000_0000;
            e.o = 1'b1;
        end
`endif
        return e;
    endfunction

    exp_t        sb[$];
    exp_t        e_pop;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_r;
    logic [3:0]  prev_t;
    logic        prev_o;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_result", bus.result, prev_r);
                chk("hold_tag", bus.out_tag, prev_t);
                chk("hold_ovf", bus.ovf, prev_o);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e_pop = sb.pop_front();
                    chk("result", bus.result, e_pop.r);
                    chk("out_tag", bus.out_tag, e_pop.t);
                    chk("ovf", bus.ovf, e_pop.o);
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.a, bus.b, bus.in_tag));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_r     = bus.result;
            prev_t     = bus.out_tag;
            prev_o     = bus.ovf;
        end
    end

    // Offers a pair and returns 1ns after the edge that accepted it.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.in_tag   = t;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                           input logic [31:0] exp_r, input logic exp_o);
        drive(a, b, t);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", bus.out_valid, 1'b0);
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            chk("lat_early", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("dir_result", bus.result, exp_r);
        chk("dir_tag", bus.out_tag, t);
        chk("dir_ovf", bus.ovf, exp_o);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(32'h0001_8000, 32'h0002_0000, 4'd3, 32'h0003_0000, 1'b0);
        run_one(32'hFFFE_8000, 32'h0002_0000, 4'd5, 32'hFFFD_0000, 1'b0);
        run_one(32'h0000_0001, 32'h0000_8000, 4'd6, (RND != 0) ? 32'h1 : 32'h0, 1'b0);
        run_one(32'h7FFF_0000, 32'h0002_0000, 4'd7, EXP_BIGPOS, OVF_BIGPOS);
        run_one(32'h8000_0000, 32'h0002_0000, 4'd8, EXP_BIGNEG, OVF_BIGNEG);

        fork
            begin
                for (int i = 0; i < 8; i++) drive($urandom, $urandom, 4'(i));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 70000));
            bus.b         = ($urandom_range(0, 1) == 1) ? $urandom : -32'($urandom_range(0, 70000));
            bus.in_tag    = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        drive(32'h0003_0000, 32'h0001_0000, 4'd9);
        drive(32'h0004_0000, 32'h0001_0000, 4'd10);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_fl_valid", bus.out_valid, 1'b0);
        chk("rst_fl_result", bus.result, 32'h0);
        chk("rst_fl_tag", bus.out_tag, 4'h0);
        chk("rst_fl_ovf", bus.ovf, 1'b0);
        chk("rst_fl_ready", bus.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        run_one(32'h0001_8000, 32'h0002_0000, 4'd11, 32'h0003_0000, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fx_mul_pipe.md
FX_MUL_PIPE -- requirements
Module: fx_mul_pipe

Interface
REQ-001 Parameter WIDTH, 32, operand and result width in bits; legal range 4..64.
REQ-002 Parameter QFRAC, 16, fractional bits of a, b and result; legal range 1..WIDTH-1.
REQ-003 Parameter LATENCY, 2, pipeline depth in cycles; legal minimum 1.
REQ-004 Parameter ROUND, 1, rounding mode: 0 = truncate toward minus infinity, 1 = round half up.
REQ-005 Parameter TAGW, 4, width of the sideband tag; legal minimum 1.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  1  operand pair offered.
REQ-009 in_ready  out  1  block accepts the offered pair this cycle.
REQ-010 a, b  in  WIDTH each  signed Q(WIDTH-QFRAC).QFRAC operands.
REQ-011 in_tag  in  TAGW  opaque sideband carried alongside the operands.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 result  out  WIDTH  signed fixed-point product.
REQ-015 out_tag  out  TAGW  in_tag of the same transaction.
REQ-016 ovf  out  1  result was saturated; qualified by out_valid.

Function
REQ-017 Transfers SHALL occur on in_valid&&in_ready (input side) and on out_valid&&out_ready (output side).
REQ-018 Pipeline stalls SHALL be global: stall = out_valid && !out_ready; in_ready = !stall, driven combinationally.
REQ-019 With no stall, a pair accepted at edge k SHALL present out_valid=1 with its result after edge k+LATENCY.
REQ-020 While stalled, every stage, valid bit and tag SHALL hold; result, out_tag and ovf SHALL stay stable.
REQ-021 Bubbles SHALL propagate unchanged and are not compressed.
REQ-022 Order SHALL be preserved; no transaction SHALL be dropped or duplicated.
REQ-023 Arithmetic: p = a*b as a full 2*WIDTH signed product; if ROUND=1, p += 2^(QFRAC-1); then s = p >>> QFRAC (arithmetic shift).
REQ-024 Back-to-back accepts SHALL sustain one result per cycle when out_ready is held 1.
REQ-025 The output stage SHALL be registered; result, out_tag and ovf SHALL not depend combinationally on the inputs.
REQ-026 If out_ready and in_valid are both 1 while the output is full, the block SHALL retire the output and accept the new pair in the same cycle.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear all stage valid bits, out_valid, result, out_tag, ovf and the data registers to 0.
REQ-028 Transactions in flight at reset SHALL be discarded; in_ready SHALL be 1 during reset and after release.
REQ-029 The first accept after reset release SHALL follow the latency in REQ-019.

Configuration
REQ-030 Macro FXMUL_SAT_EN defined: s SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and ovf SHALL be 1 exactly when a clamp occurs.
REQ-031 Macro FXMUL_SAT_EN undefined: result SHALL be s[WIDTH-1:0] (wrap), ovf SHALL be tied to 0, and no clamp logic SHALL exist.

Verification (WIDTH=32, QFRAC=16, LATENCY=2, out_ready=1 unless stated)
REQ-032 a=0x00018000, b=0x00020000, tag=3, accepted at edge k -> result=0x00030000, out_tag=3, ovf=0, out_valid high after edge k+2.
REQ-033 a=0xFFFE8000 (-1.5), b=0x00020000 -> result=0xFFFD0000; a=0x00000001, b=0x00008000 -> ROUND=1 gives 0x00000001, ROUND=0 gives 0x00000000.
REQ-034 a=0x7FFF0000, b=0x00020000 -> with FXMUL_SAT_EN: result=0x7FFFFFFF, ovf=1; without it: result=0xFFFE0000, ovf=0; a=0x80000000, b=0x00020000 with FXMUL_SAT_EN -> 0x80000000, ovf=1.
REQ-035 Stream 8 back-to-back pairs, tags 0..7, then drop out_ready for 5 cycles mid-stream -> in_ready=0 while stalled, held outputs stable, all 8 results delivered in tag order, no loss.
REQ-036 Assert rst_n low with 2 transactions in flight -> out_valid, result, ovf=0 immediately; after release no stale result appears; next pair returns after 2 cycles.
